apb_master: RTL and testbench
=============================

# apb_master

APB requester that turns a single-beat command/response interface into APB3 SETUP/ACCESS transfers. It is the initiator end of the APB link: its `psel`/`penable`/`paddr`/`pwrite`/`pwdata` outputs drive the APB slave, and it samples that slave's `prdata`/`pready`. One transfer is in flight at a time. Read data and completion status return on a registered response pulse.

## Interface

Parameters:
- `ADDR_W`, default 10: APB address width.
- `DATA_W`, default 32: APB data width.
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS cycles before abort. Used only when `APB_MASTER_TIMEOUT_EN` is defined. Legal range 1..255.

Ports:
- `clk`  in  1  — single clock; all logic is rising-edge.
- `reset`  in  1  — synchronous, active-high reset.
- `cmd_valid_i`  in  1  — command request.
- `cmd_ready_o`  out  1  — master can accept a command; high only in IDLE.
- `cmd_write_i`  in  1  — 1 = write, 0 = read.
- `cmd_addr_i`  in  ADDR_W  — transfer address.
- `cmd_wdata_i`  in  DATA_W  — write data; ignored for reads.
- `rsp_valid_o`  out  1  — one-cycle completion pulse; no backpressure.
- `rsp_rdata_o`  out  DATA_W  — read data. Zero for writes and aborted transfers.
- `rsp_err_o`  out  1  — transfer aborted by timeout. Valid with `rsp_valid_o`.
- `psel_o`  out  1  — APB select.
- `penable_o`  out  1  — APB enable.
- `paddr_o`  out  ADDR_W  — APB address.
- `pwrite_o`  out  1  — APB direction.
- `pwdata_o`  out  DATA_W  — APB write data.
- `prdata_i`  in  DATA_W  — APB read data.
- `pready_i`  in  1  — APB ready; sampled only in ACCESS.

## Operation

- The FSM has three states: IDLE, SETUP and ACCESS. All outputs are registered or decoded from state; there is no combinational path from input to output.
- IDLE:
  - `cmd_ready_o` = 1, `psel_o` = 0, `penable_o` = 0.
  - When `cmd_valid_i` is high, capture `cmd_addr_i`, `cmd_write_i` and `cmd_wdata_i` into `paddr_o`, `pwrite_o` and `pwdata_o`, then go to SETUP.
- SETUP:
  - `psel_o` = 1, `penable_o` = 0.
  - Always go to ACCESS next cycle.
- ACCESS:
  - `psel_o` = 1, `penable_o` = 1.
  - When `pready_i` is high:
    - Capture `prdata_i` into `rsp_rdata_o` if the transfer is a read; load 0 if it is a write.
    - Set `rsp_valid_o` = 1 and `rsp_err_o` = 0 for the next cycle.
    - Go to IDLE.
  - When `pready_i` is low, stay in ACCESS; all APB outputs hold.
- `paddr_o`, `pwrite_o` and `pwdata_o` hold their last values in IDLE and change only on command acceptance.
- `rsp_rdata_o` holds its value between responses.
- Commands presented outside IDLE are not accepted (`cmd_ready_o` = 0). The requester must hold `cmd_valid_i` and the command fields until it sees `cmd_ready_o` high.
- `rsp_valid_o` is a single-cycle pulse and coincides with the first IDLE cycle after the transfer. A command accepted in that same cycle is legal.
- Reset, including mid-transfer: the next state is IDLE and all outputs go to 0 (`cmd_ready_o` = 1 once in IDLE). The in-flight transfer is dropped with no response.

## Timing

- Cycle numbering for one transfer with zero wait states:
  - Cycle 0: accept (IDLE).
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS, `pready_i` = 1.
  - Cycle 3: `rsp_valid_o` = 1 and `cmd_ready_o` = 1.
- Minimum spacing between accepted commands is 3 cycles.
- Each ACCESS cycle with `pready_i` low adds one cycle of latency.
- `pready_i` is ignored in IDLE and SETUP.
- Reset values: `psel_o`, `penable_o`, `paddr_o`, `pwrite_o`, `pwdata_o`, `rsp_valid_o`, `rsp_rdata_o` and `rsp_err_o` are all 0. `cmd_ready_o` = 1.

## Configuration

- Macro: `APB_MASTER_TIMEOUT_EN`.
- Defined:
  - The wait counter (`$clog2(TIMEOUT_CYCLES+1)` bits) clears on entry to ACCESS and increments on each ACCESS cycle with `pready_i` low.
  - If `pready_i` is low and the count equals `TIMEOUT_CYCLES-1`, the transfer aborts:
    - Next cycle: IDLE, `psel_o` = 0, `penable_o` = 0.
    - `rsp_valid_o` = 1, `rsp_err_o` = 1, `rsp_rdata_o` = 0.
  - `pready_i` high in the final allowed cycle completes normally; completion has priority over timeout.
  - A transfer therefore spends at most `TIMEOUT_CYCLES` cycles in ACCESS.
- Undefined: there is no counter, ACCESS waits indefinitely, and `rsp_err_o` is tied to 0.

## Test plan

- Write, addr 0x155, data 0xDEADBEEF, `pready_i` high in the first ACCESS cycle:
  - SETUP in cycle 1 and ACCESS in cycle 2, with `paddr_o` = 0x155 and `pwrite_o` = 1.
  - `rsp_valid_o` in cycle 3 with `rsp_rdata_o` = 0 and `rsp_err_o` = 0.
- Read, addr 0x155, 3 wait states, `prdata_i` = 0xDEADBEEF at `pready_i`:
  - ACCESS lasts 4 cycles; `rsp_valid_o` comes in cycle 6 with `rsp_rdata_o` = 0xDEADBEEF.
  - The APB outputs stay stable throughout ACCESS.
- Back-to-back commands with `cmd_valid_i` held high:
  - Accepts occur in cycles 0, 3 and 6.
  - `cmd_ready_o` is low in all SETUP and ACCESS cycles.
- `reset` asserted during ACCESS:
  - Next cycle: all outputs are 0, `cmd_ready_o` = 1, and no `rsp_valid_o`.
  - A following read completes normally.
- With `APB_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, `pready_i` held low:
  - `rsp_valid_o` = 1 and `rsp_err_o` = 1 after 4 ACCESS cycles, and `psel_o` drops.
  - In a second run, `pready_i` high in the 4th ACCESS cycle completes with `rsp_err_o` = 0.
- Without the macro, `pready_i` held low for 100 cycles:
  - The FSM stays in ACCESS and no `rsp_valid_o` is seen.
  - Raising `pready_i` then completes the transfer normally.

Source files
------------

// File: rtl/apb_master.sv
// APB3 requester: single-beat command/response to SETUP/ACCESS transfers.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e            state_q;
  logic              cmd_ready_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             rsp_err_q;
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  // State and every output are updated together so all outputs come from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            paddr_q     <= cmd_addr_i;
            pwrite_q    <= cmd_write_i;
            pwdata_q    <= cmd_wdata_i;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          // Completion wins over timeout in the last allowed cycle.
          if (pready_i) begin
            rsp_rdata_q <= pwrite_q ? '0 : prdata_i;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
`endif
        end
        default: begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboarded bench for apb_master; timeout cases build when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              psel_o;
  logic              penable_o;
  logic [ADDR_W-1:0] paddr_o;
  logic              pwrite_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  apb_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid_o), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err_o), 64'(e.err));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_rspv", 64'(rsp_valid_o), 64'(0));
      check("idle_psel", 64'(psel_o), 64'(0));
      check("idle_ready", 64'(cmd_ready_o), 64'(1));
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the response cycle.
  task automatic xfer(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                      input int waits, input logic [DATA_W-1:0] rd, input bit abort, input bit hold);
    rsp_t e;
    check("acc_ready_idle", 64'(cmd_ready_o), 64'(1));
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    e.err   = abort;
    e.rdata = (wr || abort) ? '0 : rd;
    exp_q.push_back(e);
    pready_i = 1'b1;
    prdata_i = 32'($urandom);
    @(negedge clk);
    check("setup_psel", 64'(psel_o), 64'(1));
    check("setup_pen", 64'(penable_o), 64'(0));
    check("setup_ready", 64'(cmd_ready_o), 64'(0));
    check("setup_paddr", 64'(paddr_o), 64'(addr));
    check("setup_pwrite", 64'(pwrite_o), 64'(wr));
    if (wr) check("setup_pwdata", 64'(pwdata_o), 64'(wd));
    if (!hold) cmd_valid_i = 1'b0;
    pready_i = 1'b1;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      check("acc_psel", 64'(psel_o), 64'(1));
      check("acc_pen", 64'(penable_o), 64'(1));
      check("acc_ready", 64'(cmd_ready_o), 64'(0));
      check("acc_paddr", 64'(paddr_o), 64'(addr));
      check("acc_pwrite", 64'(pwrite_o), 64'(wr));
      if (wr) check("acc_pwdata", 64'(pwdata_o), 64'(wd));
      check("acc_rspv", 64'(rsp_valid_o), 64'(0));
      pready_i = (i == waits) && !abort;
      prdata_i = (pready_i && !wr) ? rd : 32'($urandom);
    end
    @(negedge clk);
    pready_i = 1'b0;
    check("done_rspv", 64'(rsp_valid_o), 64'(1));
    check("done_ready", 64'(cmd_ready_o), 64'(1));
    check("done_psel", 64'(psel_o), 64'(0));
    check("done_pen", 64'(penable_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    prdata_i    = '0;
    pready_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(cmd_ready_o), 64'(1));
    check("rst_psel", 64'(psel_o), 64'(0));
    check("rst_pen", 64'(penable_o), 64'(0));
    check("rst_paddr", 64'(paddr_o), 64'(0));
    check("rst_pwrite", 64'(pwrite_o), 64'(0));
    check("rst_pwdata", 64'(pwdata_o), 64'(0));
    check("rst_rspv", 64'(rsp_valid_o), 64'(0));
    check("rst_rdata", 64'(rsp_rdata_o), 64'(0));
    check("rst_err", 64'(rsp_err_o), 64'(0));
    reset = 1'b0;
    idle(2);

    // Zero-wait write, then 3-wait read.
    xfer(1'b1, 10'h155, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b0);
    idle(1);
    xfer(1'b0, 10'h155, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(2);
    check("rdata_hold", 64'(rsp_rdata_o), 64'(32'hDEADBEEF));

    // Back-to-back with cmd_valid held: accepts every 3 cycles.
    xfer(1'b1, 10'h001, 32'h11112222, 0, 32'h0, 1'b0, 1'b1);
    xfer(1'b0, 10'h3FF, 32'h0, 0, 32'hA5A5F00F, 1'b0, 1'b1);
    xfer(1'b1, 10'h2AA, 32'h33334444, 0, 32'h0, 1'b0, 1'b0);
    idle(1);

    // Reset during ACCESS drops the transfer silently.
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b0;
    cmd_addr_i  = 10'h0F0;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    check("pre_rst_pen", 64'(penable_o), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", 64'(cmd_ready_o), 64'(1));
    check("midrst_psel", 64'(psel_o), 64'(0));
    check("midrst_pen", 64'(penable_o), 64'(0));
    check("midrst_paddr", 64'(paddr_o), 64'(0));
    check("midrst_rspv", 64'(rsp_valid_o), 64'(0));
    check("midrst_rdata", 64'(rsp_rdata_o), 64'(0));
    idle(2);
    xfer(1'b0, 10'h0F0, 32'h0, 1, 32'h0BADF00D, 1'b0, 1'b0);
    idle(1);

`ifdef APB_MASTER_TIMEOUT_EN
    // pready stuck low aborts after TIMEOUT ACCESS cycles.
    xfer(1'b0, 10'h123, 32'h0, TIMEOUT - 1, 32'h0, 1'b1, 1'b0);
    idle(1);
    // pready high in the last allowed cycle completes normally.
    xfer(1'b0, 10'h124, 32'h0, TIMEOUT - 1, 32'hCAFEBABE, 1'b0, 1'b0);
    idle(1);
`else
    // No timeout: ACCESS waits 100 cycles, then completes.
    xfer(1'b0, 10'h124, 32'h0, 100, 32'hCAFEBABE, 1'b0, 1'b0);
    idle(1);
`endif

    idle(2);
    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
